// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operand, HI/LO access and busy/done handshake between control path and the multiply/divide unit
interface mult_div_unit_if #(parameter int N = 32);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] inA;
    logic [N-1:0] inB;
    logic         hi_wen;
    logic         lo_wen;
    logic [N-1:0] wd;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    modport master (output start, op, inA, inB, hi_wen, lo_wen, wd,
                    input busy, done, div_by_zero, hi, lo);
    modport slave  (input start, op, inA, inB, hi_wen, lo_wen, wd,
                    output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiplier / restoring divider holding HI/LO
module mult_div_unit #(parameter int N = 32) (
    input logic clock,
    input logic reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [N-1:0] a, hi_r, lo_r, mag_a, mag_b, res_hi, res_lo;
    logic [2*N-1:0] p, p_step, prod;
    logic [N:0] sum, trial;
    logic is_div, sa, sb, done_r, dz_r, dz, accept;
    assign dz = state == IDLE && bus.start && bus.op[1] && bus.inB == '0;
    assign accept = state == IDLE && bus.start && !dz;
    assign mag_a = (bus.op[0] && bus.inA[N-1]) ? -bus.inA : bus.inA;
    assign mag_b = (bus.op[0] && bus.inB[N-1]) ? -bus.inB : bus.inB;
    // p holds {acc, multiplier} for multiply and {remainder, quotient} for divide
    assign sum = {1'b0, p[2*N-1:N]} + {1'b0, p[0] ? a : '0};
    assign trial = p[2*N-1:N-1] - {1'b0, a};
    assign p_step = is_div ? (trial[N] ? {p[2*N-2:0], 1'b0} : {trial[N-1:0], p[N-2:0], 1'b1})
                           : {sum, p[N-1:1]};
    assign prod = (sa ^ sb) ? -p : p;
    assign res_lo = is_div ? ((sa ^ sb) ? -p[N-1:0] : p[N-1:0]) : prod[N-1:0];
    assign res_hi = is_div ? (sa ? -p[2*N-1:N] : p[2*N-1:N]) : prod[2*N-1:N];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (state == IDLE && accept) state_n = RUN;
        else if (state == RUN && cnt == CW'(N-1)) state_n = FIX;
        else if (state == FIX) state_n = IDLE;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            a      <= '0;
            p      <= '0;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= dz || state == FIX;
            if (dz) dz_r <= 1'b1;
            else if (accept) dz_r <= 1'b0;
            if (accept) begin
                cnt    <= '0;
                is_div <= bus.op[1];
                sa     <= bus.op[0] & bus.inA[N-1];
                sb     <= bus.op[0] & bus.inB[N-1];
                a      <= bus.op[1] ? mag_b : mag_a;
                p      <= {{N{1'b0}}, bus.op[1] ? mag_a : mag_b};
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                p   <= p_step;
            end
            if (state == FIX) begin
                hi_r <= res_hi;
                lo_r <= res_lo;
            end else if (state == IDLE && !bus.start) begin
                if (bus.hi_wen) hi_r <= bus.wd;
                if (bus.lo_wen) lo_r <= bus.wd;
            end
        end
    end
    assign bus.busy = state != IDLE;
    assign bus.done = done_r;
    assign bus.div_by_zero = dz_r;
    assign bus.hi = hi_r;
    assign bus.lo = lo_r;
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit beside the ALU in the MIPS datapath.
- Consumes register-file read data (rdA, rdB) and holds the architectural HI/LO registers.
- HI/LO are read back for mfhi/mflo write-back.
- Implements multu, mult, divu and div using a 32-iteration shift-add multiplier and a 32-iteration restoring divider, with a busy/done handshake toward the control path.

Parameters:
- N, 32, operand width; HI and LO are each N bits; iteration count equals N.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request an operation; sampled on posedge clock.
- op  input  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
- inA  input  N  multiplicand or dividend (rs).
- inB  input  N  multiplier or divisor (rt).
- hi_wen  input  1  mthi write enable.
- lo_wen  input  1  mtlo write enable.
- wd  input  N  mthi/mtlo write data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated or when a divide-by-zero is detected.
- div_by_zero  output  1  last accepted divide had inB == 0.
- hi  output  N  HI register.
- lo  output  N  LO register.

Behaviour:
- Reset (reset == 0, asynchronous): state IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; the iteration counter and working registers are cleared.
- Reset asserted mid-operation: the operation is abandoned and the unit returns to the reset values immediately.
- States: IDLE, RUN, FIX.
- IDLE, start==1, not a divide by zero: capture operand magnitudes and sign bits (signed ops only; op[0]==1 means signed). Clear the counter and go to RUN. busy=1 from this edge.
- IDLE, start==1, op[1]==1 and inB==0: stay in IDLE; done=1 and div_by_zero=1 for the next cycle; hi/lo unchanged.
- Start accepted (E0): div_by_zero is cleared, unless that start is itself a divide by zero.
- RUN: one iteration per cycle, counter 0..N-1.
  - Multiply: if the multiplier LSB is 1, add the multiplicand to the upper half of a 2N-bit accumulator; then shift right one bit. Carry out is kept.
  - Divide (restoring): shift {remainder, quotient} left one bit; trial-subtract the divisor from the remainder; if the result is non-negative, keep it and set quotient LSB = 1.
  - On the edge completing iteration N-1 (edge E0+N), go to FIX.
- FIX (one cycle):
  - Signed results: the product is negated if sign(inA) ^ sign(inB). The quotient is negated on the same condition. The remainder takes the sign of the dividend.
  - Write results: multiply gives hi = product[2N-1:N], lo = product[N-1:0]. Divide gives lo = quotient, hi = remainder.
  - At edge E0+N+1: hi/lo updated, busy=0, done=1 for one cycle, state IDLE.
- Latency: N+1 cycles from the start edge to valid hi/lo (33 for N=32).
- done: high exactly one cycle and cleared on the next edge unconditionally. A start on the done cycle is accepted normally.
- start while busy is ignored; there is no queueing.
- hi_wen/lo_wen:
  - Honoured only in IDLE, on the posedge, when no start is accepted that cycle.
  - Ignored while busy or when start is accepted in the same cycle.
  - hi_wen and lo_wen together write wd to both.
- Signed overflow -2^31 / -1 gives lo = 0x80000000, hi = 0. No trap is raised.
- Operands are captured at the start edge; inA/inB/op changes during RUN have no effect.

Test Plan:
- Unsigned multiply: multu 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles, done pulses for 1 cycle, hi = 0xFFFFFFFE, lo = 0x00000001, busy low thereafter.
- Signed multiply: mult 0xFFFFFFFD (-3) × 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- Signed divide: div 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- Unsigned divide: divu 100 / 7 -> lo = 14, hi = 2.
- Signed overflow: div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- Divide by zero: with hi=0x11, lo=0x22, divu 5 / 0 -> done and div_by_zero high on the next cycle, busy never asserts, hi=0x11, lo=0x22. A following multu clears div_by_zero.
- Handshake and reset:
  - A second start with different operands at cycle 5 of RUN is ignored; the result matches the first operation.
  - mthi of 0xABCD while busy is ignored; mthi in IDLE writes hi = 0xABCD.
  - Reset asserted at cycle 10 of RUN -> busy=0, done=0, hi=0, lo=0, asynchronously.
